// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator: accepts note events, scans voices to pick a slot
// (retrigger > free > steal-oldest), drives per-voice increments and step/reset pulses.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned SAMPLE_DIV = 2268,
    parameter int unsigned AGE_W      = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     note_valid_in,
    output logic                     note_ready_out,
    input  logic                     note_on_in,
    input  logic [6:0]               note_num_in,
    input  logic [31:0]              phase_incr_in,
    output logic                     sample_tick_out,
    output logic [NUM_VOICES-1:0]    voice_step_out,
    output logic [NUM_VOICES-1:0]    voice_rst_out,
    output logic [NUM_VOICES-1:0]    voice_active_out,
    output logic [NUM_VOICES*32-1:0] voice_incr_out
);
    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;
    state_t state, state_next;

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic [6:0]       note   [NUM_VOICES];
    logic [31:0]      incr   [NUM_VOICES];
    logic [AGE_W-1:0] age    [NUM_VOICES];

    logic             ev_on;
    logic [6:0]       ev_num;
    logic [31:0]      ev_incr;
    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx, target;
    logic [AGE_W-1:0] old_age;
    logic             transfer, do_assign, do_release;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (note_valid_in && note_ready_out) state_next = SEARCH;
            SEARCH:  if (idx == IDX_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        transfer   = (state == IDLE) && note_valid_in && note_ready_out;
        target     = old_idx;
        if (match_found)     target = match_idx;
        else if (free_found) target = free_idx;
        do_assign  = (state == COMMIT) && ev_on;
        do_release = (state == COMMIT) && !ev_on && match_found;
    end

    assign sample_tick_out = (div_cnt == DIV_LAST);
    assign voice_step_out  = voice_active_out & {NUM_VOICES{sample_tick_out}};

    always_comb begin
        voice_incr_out = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++)
            voice_incr_out[32*i +: 32] = incr[i];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_cnt          <= '0;
            idx              <= '0;
            note_ready_out   <= 1'b1;
            voice_rst_out    <= '0;
            voice_active_out <= '0;
            ev_on            <= 1'b0;
            ev_num           <= '0;
            ev_incr          <= '0;
            match_found      <= 1'b0;
            free_found       <= 1'b0;
            old_found        <= 1'b0;
            match_idx        <= '0;
            free_idx         <= '0;
            old_idx          <= '0;
            old_age          <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                note[i] <= '0;
                incr[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            div_cnt       <= sample_tick_out ? '0 : div_cnt + DIV_W'(1);
            voice_rst_out <= '0;

            if (transfer) begin
                ev_on          <= note_on_in;
                ev_num         <= note_num_in;
                ev_incr        <= phase_incr_in;
                idx            <= '0;
                match_found    <= 1'b0;
                free_found     <= 1'b0;
                old_found      <= 1'b0;
                note_ready_out <= 1'b0;
            end

            // One voice per cycle; ages may tick mid-scan, the value seen at scan time is used.
            if (state == SEARCH) begin
                idx <= idx + IDX_W'(1);
                if (voice_active_out[idx] && note[idx] == ev_num && !match_found) begin
                    match_found <= 1'b1;
                    match_idx   <= idx;
                end
                if (!voice_active_out[idx] && !free_found) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end
                if (voice_active_out[idx] && (!old_found || age[idx] > old_age)) begin
                    old_found <= 1'b1;
                    old_idx   <= idx;
                    old_age   <= age[idx];
                end
            end

            if (state == COMMIT) note_ready_out <= 1'b1;

            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (do_assign && target == IDX_W'(i)) begin
                    note[i]             <= ev_num;
                    incr[i]             <= ev_incr;
                    age[i]              <= '0;
                    voice_active_out[i] <= 1'b1;
                    voice_rst_out[i]    <= 1'b1;
                end else begin
                    if (sample_tick_out && voice_active_out[i] && age[i] != '1)
                        age[i] <= age[i] + AGE_W'(1);
                    if (do_release && match_idx == IDX_W'(i))
                        voice_active_out[i] <= 1'b0;
                end
            end
        end
    end
endmodule
